// File: rtl/mp64_memory_pkg.sv
// Shared definitions for the MP64 memory block.
//   SIZE_*             access size encodings (byte, half, word, double)
//   BRAM_BYTES_DEFAULT default internal BRAM size in bytes
//   MMIO_HI            highest byte address of the external / MMIO window
//   mem_req_t          latched request fields as forwarded to the external port
//   size_mask/size_be/align_addr  helpers shared by the datapath
package mp64_memory_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  localparam int unsigned BRAM_BYTES_DEFAULT = 1048576;
  localparam logic [63:0] MMIO_HI = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        wen;
    logic [1:0]  size;
  } mem_req_t;

  // Right-justified data mask for an access size.
  function automatic logic [63:0] size_mask(input logic [1:0] size);
    logic [63:0] m;
    unique case (size)
      SIZE_B:  m = 64'h0000_0000_0000_00FF;
      SIZE_H:  m = 64'h0000_0000_0000_FFFF;
      SIZE_W:  m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

  // Byte enables for an access at byte lane 0.
  function automatic logic [7:0] size_be(input logic [1:0] size);
    logic [7:0] be;
    unique case (size)
      SIZE_B:  be = 8'h01;
      SIZE_H:  be = 8'h03;
      SIZE_W:  be = 8'h0F;
      default: be = 8'hFF;
    endcase
    return be;
  endfunction

  // Round an address down to the natural boundary of its size.
  function automatic logic [63:0] align_addr(input logic [63:0] addr, input logic [1:0] size);
    logic [63:0] a;
    unique case (size)
      SIZE_B:  a = addr;
      SIZE_H:  a = {addr[63:1], 1'b0};
      SIZE_W:  a = {addr[63:2], 2'b00};
      default: a = {addr[63:3], 3'b000};
    endcase
    return a;
  endfunction

endpackage

// File: rtl/mp64_memory_if.sv
// Bus bundle between a requester and mp64_memory, plus the external
// (off-BRAM) request/response port.
//   master: requester side, also answers the external port (ext_rdata/ext_ack)
//   slave:  the memory block
interface mp64_memory_if;

  logic        req;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        wen;
  logic [1:0]  size;
  logic [63:0] rdata;
  logic        ack;

  logic        ext_req;
  logic [63:0] ext_addr;
  logic [63:0] ext_wdata;
  logic        ext_wen;
  logic [1:0]  ext_size;
  logic [63:0] ext_rdata;
  logic        ext_ack;

  modport master (
    output req, addr, wdata, wen, size,
    input  rdata, ack,
    input  ext_req, ext_addr, ext_wdata, ext_wen, ext_size,
    output ext_rdata, ext_ack
  );

  modport slave (
    input  req, addr, wdata, wen, size,
    output rdata, ack,
    output ext_req, ext_addr, ext_wdata, ext_wen, ext_size,
    input  ext_rdata, ext_ack
  );

endinterface

// File: rtl/mp64_bram.sv
// Single-port 64-bit wide RAM with per-byte write enables.
//   clk   clock
//   en    access enable (read and/or write this cycle)
//   we    byte write enables, lane i = wdata[8i+7:8i]
//   addr  word address
//   wdata write data
//   rdata registered read data, valid the cycle after en (old data on write)
// The array has no reset so its contents survive a block reset.
module mp64_bram #(
  parameter int unsigned Depth     = 131072,
  parameter int unsigned AddrWidth = $clog2(Depth)
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [7:0]           we,
  input  logic [AddrWidth-1:0] addr,
  input  logic [63:0]          wdata,
  output logic [63:0]          rdata
);

  logic [63:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 8; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mp64_memory.sv
// MP64 memory block: internal BRAM below BRAM_BYTES, everything else is
// forwarded to the external port with a bounded wait.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         slave side of mp64_memory_if (host request/response and
//               external request/response)
// Every transaction ends with a single-cycle ack; the block then sits in DONE
// until req drops, so a held req never starts a second transaction.
module mp64_memory
  import mp64_memory_pkg::*;
#(
  parameter int unsigned BRAM_BYTES  = BRAM_BYTES_DEFAULT,
  parameter int unsigned EXT_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  mp64_memory_if.slave bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BRAM_RD  = 2'd1;
  localparam logic [1:0] EXT_WAIT = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  localparam int unsigned Words = BRAM_BYTES / 8;
  localparam int unsigned AW    = $clog2(Words);
  localparam int unsigned CntW  = $clog2(EXT_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(EXT_TIMEOUT - 1);

  logic [1:0]      state_q, state_d;
  logic            ack_q, ack_d;
  logic [63:0]     rdata_q, rdata_d;
  logic            ext_req_q, ext_req_d;
  mem_req_t        ext_q, ext_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      size_q, size_d;
  logic [2:0]      off_q, off_d;
  logic            wen_q, wen_d;

  logic [63:0]   addr_al;
  logic          in_bram;
  logic          bram_en;
  logic [7:0]    bram_we;
  logic [63:0]   bram_wdata;
  logic [63:0]   bram_rdata;
  logic [AW-1:0] bram_addr;

  assign addr_al    = align_addr(bus.addr, bus.size);
  assign in_bram    = bus.addr < 64'(BRAM_BYTES);
  assign bram_addr  = addr_al[AW+2:3];
  assign bram_wdata = (bus.wdata & size_mask(bus.size)) << {addr_al[2:0], 3'b000};

  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    rdata_d   = rdata_q;
    ext_req_d = ext_req_q;
    ext_d     = ext_q;
    cnt_d     = cnt_q;
    size_d    = size_q;
    off_d     = off_q;
    wen_d     = wen_q;
    bram_en   = 1'b0;
    bram_we   = 8'h00;

    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          size_d = bus.size;
          off_d  = addr_al[2:0];
          wen_d  = bus.wen;
          cnt_d  = '0;
          if (in_bram) begin
            bram_en = 1'b1;
            if (bus.wen) begin
              bram_we = size_be(bus.size) << addr_al[2:0];
              ack_d   = 1'b1;
              rdata_d = '0;
              state_d = DONE;
            end else begin
              state_d = BRAM_RD;
            end
          end else begin
            ext_req_d   = 1'b1;
            ext_d.addr  = addr_al;
            ext_d.wdata = bus.wen ? bus.wdata : '0;
            ext_d.wen   = bus.wen;
            ext_d.size  = bus.size;
            state_d     = EXT_WAIT;
          end
        end
      end

      BRAM_RD: begin
        ack_d   = 1'b1;
        rdata_d = (bram_rdata >> {off_q, 3'b000}) & size_mask(size_q);
        state_d = DONE;
      end

      EXT_WAIT: begin
        // ext_ack is checked first so it wins over a coincident timeout.
        if (bus.ext_ack) begin
          ext_req_d = 1'b0;
          ack_d     = 1'b1;
          rdata_d   = wen_q ? 64'h0 : bus.ext_rdata;
          state_d   = DONE;
        end else if (cnt_q == CntLast) begin
          ext_req_d = 1'b0;
          ack_d     = 1'b1;
          rdata_d   = 64'hFFFF_FFFF_FFFF_FFFF;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        if (!bus.req) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      ext_req_q <= 1'b0;
      ext_q     <= '0;
      cnt_q     <= '0;
      size_q    <= SIZE_B;
      off_q     <= '0;
      wen_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      ext_req_q <= ext_req_d;
      ext_q     <= ext_d;
      cnt_q     <= cnt_d;
      size_q    <= size_d;
      off_q     <= off_d;
      wen_q     <= wen_d;
    end
  end

  // The RAM array is not reset, so its strobes are gated by rst_n directly:
  // a req held during reset must not write.
  mp64_bram #(
    .Depth(Words),
    .AddrWidth(AW)
  ) u_bram (
    .clk  (clk),
    .en   (bram_en & rst_n),
    .we   (bram_we & {8{rst_n}}),
    .addr (bram_addr),
    .wdata(bram_wdata),
    .rdata(bram_rdata)
  );

  assign bus.ack       = ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.ext_req   = ext_req_q;
  assign bus.ext_addr  = ext_q.addr;
  assign bus.ext_wdata = ext_q.wdata;
  assign bus.ext_wen   = ext_q.wen;
  assign bus.ext_size  = ext_q.size;

endmodule

// File: tb/tb_mp64_memory.sv
module tb_mp64_memory;

  localparam int unsigned BramBytes  = 1048576;
  localparam int unsigned ExtTimeout = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mp64_memory_if bus();

  mp64_memory #(
    .BRAM_BYTES(BramBytes),
    .EXT_TIMEOUT(ExtTimeout)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Byte-addressed reference memory.
  logic [7:0] ref_mem [logic [63:0]];

  // Results of the most recent do_txn.
  logic [63:0] r_rdata;
  int          r_lat;
  int          r_ext_hi;
  int          r_nack;
  logic        r_ext_req_at_ack;
  logic [63:0] r_ext_addr;
  logic [63:0] r_ext_wdata;
  logic        r_ext_wen;
  logic [1:0]  r_ext_size;
  int          r_ext_unstable;

  function automatic logic [63:0] m_align(input logic [63:0] a, input logic [1:0] s);
    logic [63:0] n;
    n = 64'd1 << s;
    return a - (a % n);
  endfunction

  function automatic logic [63:0] m_read(input logic [63:0] a, input logic [1:0] s);
    logic [63:0] al;
    logic [63:0] v;
    al = m_align(a, s);
    v  = '0;
    for (int i = 0; i < (1 << s); i++) begin
      v[8*i +: 8] = ref_mem.exists(al + 64'(i)) ? ref_mem[al + 64'(i)] : 8'h00;
    end
    return v;
  endfunction

  task automatic m_write(input logic [63:0] a, input logic [1:0] s, input logic [63:0] d);
    logic [63:0] al;
    al = m_align(a, s);
    for (int i = 0; i < (1 << s); i++) begin
      ref_mem[al + 64'(i)] = d[8*i +: 8];
    end
  endtask

  // One transaction. ext_delay: cycle of ext_req high during which ext_ack is
  // presented (-1 = never). hold: extra cycles req stays high after the ack.
  task automatic do_txn(input logic [63:0] a, input logic [63:0] wd, input logic w,
                        input logic [1:0] s, input int ext_delay, input logic [63:0] ext_val,
                        input int hold);
    @(negedge clk);
    bus.req   = 1'b1;
    bus.addr  = a;
    bus.wdata = wd;
    bus.wen   = w;
    bus.size  = s;
    r_rdata = '0; r_lat = 0; r_ext_hi = 0; r_nack = 0; r_ext_unstable = 0;
    r_ext_req_at_ack = 1'b0;
    for (int c = 0; c < 400 && r_nack == 0; c++) begin
      @(posedge clk); #1;
      bus.ext_ack = 1'b0;
      r_lat++;
      if (bus.ack) begin
        r_nack++;
        r_rdata = bus.rdata;
        r_ext_req_at_ack = bus.ext_req;
      end else if (bus.ext_req) begin
        r_ext_hi++;
        if (r_ext_hi == 1) begin
          r_ext_addr = bus.ext_addr; r_ext_wdata = bus.ext_wdata;
          r_ext_wen = bus.ext_wen; r_ext_size = bus.ext_size;
        end else if (bus.ext_addr !== r_ext_addr || bus.ext_wdata !== r_ext_wdata ||
                     bus.ext_wen !== r_ext_wen || bus.ext_size !== r_ext_size) begin
          r_ext_unstable++;
        end
        if (r_ext_hi == ext_delay) begin
          bus.ext_ack   = 1'b1;
          bus.ext_rdata = ext_val;
        end
      end
    end
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      if (bus.ack) r_nack++;
    end
    bus.req = 1'b0;
    @(posedge clk); #1;
    if (bus.ack) r_nack++;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", bus.ack); end
    n_cmp++; if (bus.rdata !== 64'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
    n_cmp++; if (bus.ext_req !== 1'b0) begin n_err++; $display("FAIL reset_ext_req: got %b want 0", bus.ext_req); end
    n_cmp++; if (bus.ext_addr !== 64'h0) begin n_err++; $display("FAIL reset_ext_addr: got %h want 0", bus.ext_addr); end
    n_cmp++; if (bus.ext_wdata !== 64'h0) begin n_err++; $display("FAIL reset_ext_wdata: got %h want 0", bus.ext_wdata); end
    n_cmp++; if (bus.ext_wen !== 1'b0) begin n_err++; $display("FAIL reset_ext_wen: got %b want 0", bus.ext_wen); end
    n_cmp++; if (bus.ext_size !== 2'b00) begin n_err++; $display("FAIL reset_ext_size: got %h want 0", bus.ext_size); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    do_txn(64'h100, 64'h1122334455667788, 1'b1, 2'd3, -1, 64'h0, 0);
    m_write(64'h100, 2'd3, 64'h1122334455667788);
    n_cmp++; if (r_lat !== 1 || r_nack !== 1 || r_rdata !== 64'h0) begin
      n_err++; $display("FAIL wr64: lat %0d acks %0d rdata %h, want lat 1 acks 1 rdata 0", r_lat, r_nack, r_rdata);
    end
    do_txn(64'h100, 64'h0, 1'b0, 2'd3, -1, 64'h0, 0);
    n_cmp++; if (r_rdata !== 64'h1122334455667788) begin
      n_err++; $display("FAIL rd64: got %h want 1122334455667788", r_rdata);
    end
    n_cmp++; if (r_lat !== 2 || r_nack !== 1) begin
      n_err++; $display("FAIL rd_latency: lat %0d acks %0d, want lat 2 acks 1", r_lat, r_nack);
    end
    do_txn(64'h103, 64'hFFFF_FFFF_FFFF_FFAB, 1'b1, 2'd0, -1, 64'h0, 0);
    m_write(64'h103, 2'd0, 64'hFFFF_FFFF_FFFF_FFAB);
    do_txn(64'h103, 64'h0, 1'b0, 2'd0, -1, 64'h0, 0);
    n_cmp++; if (r_rdata !== 64'hAB) begin n_err++; $display("FAIL rd_byte: got %h want ab", r_rdata); end
    do_txn(64'h100, 64'h0, 1'b0, 2'd3, -1, 64'h0, 0);
    n_cmp++; if (r_rdata !== 64'h11223344AB667788) begin
      n_err++; $display("FAIL rd64_after_byte: got %h want 11223344ab667788", r_rdata);
    end
    do_txn(64'h106, 64'h0, 1'b0, 2'd2, -1, 64'h0, 0);
    n_cmp++; if (r_rdata !== 64'h11223344) begin
      n_err++; $display("FAIL rd32_misaligned: got %h want 11223344", r_rdata);
    end
  endtask

  task automatic test_random_bram();
    logic [63:0] a, d, exp;
    logic [1:0]  s;
    logic        w;
    int          bad;
    for (int i = 0; i < 32; i++) begin
      d = {$urandom, $urandom};
      do_txn(64'h1000 + 64'(8 * i), d, 1'b1, 2'd3, -1, 64'h0, 0);
      m_write(64'h1000 + 64'(8 * i), 2'd3, d);
    end
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      a = 64'h1000 + 64'($urandom_range(0, 255));
      s = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom};
      exp = w ? 64'h0 : m_read(a, s);
      if (w) m_write(a, s, d);
      do_txn(a, d, w, s, -1, 64'h0, 0);
      n_cmp++;
      if (r_rdata !== exp || r_nack !== 1 || r_lat !== (w ? 1 : 2)) begin
        n_err++; bad++;
        if (bad < 8) $display("FAIL rand_bram[%0d]: a %h s %0d w %b got %h lat %0d acks %0d want %h",
                              i, a, s, w, r_rdata, r_lat, r_nack, exp);
      end
    end
  endtask

  task automatic test_ext();
    logic [63:0] a, d, v;
    logic [1:0]  s;
    logic        w;
    int          dl;
    do_txn(64'h0010_0000, 64'h0, 1'b0, 2'd3, 5, 64'hDEAD, 0);
    n_cmp++; if (r_rdata !== 64'hDEAD) begin n_err++; $display("FAIL ext_rd_data: got %h want dead", r_rdata); end
    n_cmp++; if (r_ext_hi !== 5 || r_nack !== 1) begin
      n_err++; $display("FAIL ext_rd_hold: ext_req cycles %0d acks %0d, want 5 and 1", r_ext_hi, r_nack);
    end
    n_cmp++; if (r_ext_req_at_ack !== 1'b0 || r_ext_unstable !== 0) begin
      n_err++; $display("FAIL ext_rd_req: ext_req at ack %b unstable %0d, want 0 0", r_ext_req_at_ack, r_ext_unstable);
    end
    n_cmp++; if (r_ext_addr !== 64'h0010_0000 || r_ext_wen !== 1'b0 || r_ext_size !== 2'd3) begin
      n_err++; $display("FAIL ext_rd_fields: addr %h wen %b size %0d want 100000 0 3", r_ext_addr, r_ext_wen, r_ext_size);
    end
    for (int i = 0; i < 8; i++) begin
      a  = 64'h0010_0000 + 64'($urandom_range(0, 4095));
      s  = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      d  = {$urandom, $urandom};
      v  = {$urandom, $urandom};
      dl = $urandom_range(1, 10);
      do_txn(a, d, w, s, dl, v, 0);
      n_cmp++;
      if (r_rdata !== (w ? 64'h0 : v) || r_ext_hi !== dl || r_nack !== 1 ||
          r_ext_addr !== m_align(a, s) || r_ext_wen !== w || r_ext_size !== s ||
          (w && r_ext_wdata !== d) || r_ext_unstable !== 0) begin
        n_err++;
        $display("FAIL ext_rand[%0d]: rdata %h ext_hi %0d acks %0d addr %h want rdata %h ext_hi %0d acks 1 addr %h",
                 i, r_rdata, r_ext_hi, r_nack, r_ext_addr, (w ? 64'h0 : v), dl, m_align(a, s));
      end
    end
  endtask

  task automatic test_timeout();
    do_txn(64'h0020_0000, 64'h0, 1'b0, 2'd3, -1, 64'h0, 0);
    n_cmp++; if (r_rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_err++; $display("FAIL timeout_rdata: got %h want all ones", r_rdata);
    end
    n_cmp++; if (r_ext_hi !== ExtTimeout || r_nack !== 1 || r_ext_req_at_ack !== 1'b0) begin
      n_err++; $display("FAIL timeout_len: ext_req cycles %0d acks %0d ext_req %b, want %0d 1 0",
                        r_ext_hi, r_nack, r_ext_req_at_ack, ExtTimeout);
    end
    do_txn(64'h0020_0008, 64'h0, 1'b0, 2'd3, ExtTimeout, 64'h1234_5678, 0);
    n_cmp++; if (r_rdata !== 64'h1234_5678 || r_nack !== 1) begin
      n_err++; $display("FAIL ack_vs_timeout: got %h acks %0d want 12345678 acks 1", r_rdata, r_nack);
    end
  endtask

  task automatic test_hold_and_reset();
    int acks;
    do_txn(64'h180, 64'hCAFE_F00D_0BAD_BEEF, 1'b1, 2'd3, -1, 64'h0, 5);
    m_write(64'h180, 2'd3, 64'hCAFE_F00D_0BAD_BEEF);
    n_cmp++; if (r_nack !== 1) begin n_err++; $display("FAIL hold_single_ack: got %0d acks want 1", r_nack); end
    do_txn(64'h180, 64'h0, 1'b0, 2'd3, -1, 64'h0, 0);
    n_cmp++; if (r_rdata !== m_read(64'h180, 2'd3)) begin
      n_err++; $display("FAIL hold_readback: got %h want %h", r_rdata, m_read(64'h180, 2'd3));
    end
    @(negedge clk);
    bus.req = 1'b1; bus.addr = 64'h0010_0040; bus.wdata = 64'h5555; bus.wen = 1'b1; bus.size = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.ext_req !== 1'b1) begin n_err++; $display("FAIL pre_reset_ext_req: got %b want 1", bus.ext_req); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.ack, bus.ext_req, bus.ext_wen} !== 3'b000 || bus.rdata !== 64'h0 ||
                 bus.ext_addr !== 64'h0 || bus.ext_wdata !== 64'h0 || bus.ext_size !== 2'd0) begin
      n_err++; $display("FAIL mid_reset_outputs: ack %b ext_req %b rdata %h ext_addr %h want all 0",
                        bus.ack, bus.ext_req, bus.rdata, bus.ext_addr);
    end
    bus.req = 1'b0;
    acks = 0;
    repeat (2) begin @(posedge clk); #1; if (bus.ack) acks++; end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (bus.ack || bus.ext_req) acks++; end
    n_cmp++; if (acks !== 0) begin n_err++; $display("FAIL reset_abort: got %0d ack/ext_req cycles want 0", acks); end
    do_txn(64'h180, 64'h0, 1'b0, 2'd3, -1, 64'h0, 0);
    n_cmp++; if (r_rdata !== 64'hCAFE_F00D_0BAD_BEEF) begin
      n_err++; $display("FAIL bram_kept: got %h want cafef00d0badbeef", r_rdata);
    end
  endtask

  initial begin
    bus.req = 1'b0; bus.addr = '0; bus.wdata = '0; bus.wen = 1'b0; bus.size = 2'd0;
    bus.ext_rdata = '0; bus.ext_ack = 1'b0;
    test_reset();
    test_directed();
    test_random_bram();
    test_ext();
    test_timeout();
    test_hold_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
